serial_arith_unit: RTL and testbench
====================================

Name: serial_arith_unit

Overview:
- Parametrised bit-serial two's-complement arithmetic unit; successor to the single-function serial negator.
- Processes fixed-length W-bit words LSB-first, one bit per enabled CLK edge, with runtime-selectable mode: pass, negate, add, subtract.
- Frames words internally with a bit counter, so no external reset is needed between words.
- Output is registered and flags the last bit and signed overflow; sits between serial data sources and serial consumers in the datapath.

Parameters:
- W, 4, word length in bits (W >= 2); sets the word boundary and the overflow-check bit position.
- CW, $clog2(W), bit-counter width (derived; not overridden).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- En  input  1  bit strobe; A, B and Mode are consumed only on edges where En=1.
- Mode  input  2  00 pass A; 01 negate A; 10 A+B; 11 A-B. Sampled only on the first bit of a word.
- A  input  1  serial operand A, LSB first.
- B  input  1  serial operand B, LSB first; ignored in modes 00 and 01.
- Y  output  1  registered serial result bit.
- Y_Valid  output  1  Y holds a new result bit this cycle.
- Y_Last  output  1  Y is the MSB of the current word.
- Ovf  output  1  signed overflow for the word; meaningful only while Y_Last=1, otherwise 0.
- Busy  output  1  a word is partly consumed (Cnt != 0).

Behaviour:
- Reset (synchronous, Reset=1 at a rising edge):
  - Cnt=0, Carry=0, ModeReg=00.
  - Y=0, Y_Valid=0, Y_Last=0, Ovf=0, Busy=0.
  - Reset overrides En. A partly processed word is discarded; the next En=1 bit is bit 0 of a new word.
- Operand mapping for bit i (M is Mode when Cnt==0, else ModeReg):
  - 00: op1=A, op2=0, cin0=0.
  - 01: op1=0, op2=~A, cin0=1.
  - 10: op1=A, op2=B, cin0=0.
  - 11: op1=A, op2=~B, cin0=1.
- Per-bit carry: cin = cin0 when Cnt==0, else Carry.
  - sum = op1 ^ op2 ^ cin
  - cout = majority(op1, op2, cin)
- On each edge with En=1 and Reset=0:
  - Y <= sum; Y_Valid <= 1.
  - Carry <= cout.
  - If Cnt==0: ModeReg <= Mode.
  - If Cnt==W-1: Y_Last <= 1, Ovf <= cin ^ cout, Cnt <= 0. Otherwise: Y_Last <= 0, Ovf <= 0, Cnt <= Cnt+1.
- Latency: result bit i is visible on Y one cycle after the edge that sampled input bit i.
- En=0 stall:
  - Cnt, Carry and ModeReg hold.
  - Next cycle: Y_Valid=0, Y_Last=0, Ovf=0; Y holds its last value.
  - Stalls of any length, anywhere in a word, must not corrupt the result.
- Mode changes while Cnt != 0 are ignored until the next word starts.
- Back-to-back words need no idle cycle. Bit 0 of word k+1 may be sampled on the edge after word k's MSB, and the carry is re-seeded from cin0.
- Pass mode never overflows. Negate of -2^(W-1) returns -2^(W-1) with Ovf=1.
- Busy is combinational from Cnt: 1 while 0 < Cnt <= W-1.

Test Plan:
- W=4, Mode=01, A=1100 fed LSB-first (0,0,1,1), En=1 -> Y bits 0,0,1,0 (0100 = +4); Y_Last on the 4th bit with Ovf=0.
- W=4, Mode=01, A=1000 -> Y=1000, Ovf=1 with Y_Last. Immediately followed by Mode=00, A=0110 -> Y=0110, Ovf=0, with no idle cycle.
- W=6, Mode=10, A=011010 (26), B=000111 (7) -> Y=100001 and Ovf=1. Then Mode=11 on the same operands -> Y=010011 (19), Ovf=0.
- W=6, Mode=11 subtract as above with En=0 for 3 cycles after bit 2 and Mode toggled to 00 during the stall -> identical result 010011; Y_Valid low only during the stall cycles; Busy=1 throughout the stall.
- Reset=1 asserted after bit 3 of a W=6 add -> all outputs 0 and Busy=0 the next cycle. A fresh word A=000001, B=000001, Mode=10 -> Y=000010, Ovf=0.
- Reset held with En=1 for several cycles -> Y_Valid stays 0 and Cnt stays 0; the first post-reset bit is treated as bit 0.

Source files
------------

// File: rtl/serial_arith_unit.sv
// Bit-serial two's-complement arithmetic unit: pass, negate, add or subtract on
// W-bit words streamed LSB-first, with registered result, last-bit and overflow flags.
module serial_arith_unit #(
  parameter int W = 4,
  localparam int CW = $clog2(W)
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       En,
  input  logic [1:0] Mode,
  input  logic       A,
  input  logic       B,
  output logic       Y,
  output logic       Y_Valid,
  output logic       Y_Last,
  output logic       Ovf,
  output logic       Busy
);

  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  logic [CW-1:0] r_cnt;
  logic          r_carry;
  logic [1:0]    r_mode;
  logic          r_y;
  logic          r_y_valid;
  logic          r_y_last;
  logic          r_ovf;

  logic          w_first;
  logic [1:0]    w_mode;
  logic          w_op1;
  logic          w_op2;
  logic          w_cin0;
  logic          w_cin;
  logic          w_sum;
  logic          w_cout;

  // The live Mode input only matters on bit 0; later bits use the latched copy.
  assign w_first = (r_cnt == '0);
  assign w_mode  = w_first ? Mode : r_mode;

  always_comb begin
    w_op1  = 1'b0;
    w_op2  = 1'b0;
    w_cin0 = 1'b0;
    case (w_mode)
      2'b00: begin
        w_op1  = A;
        w_op2  = 1'b0;
        w_cin0 = 1'b0;
      end
      2'b01: begin
        w_op1  = 1'b0;
        w_op2  = ~A;
        w_cin0 = 1'b1;
      end
      2'b10: begin
        w_op1  = B ? A : A;
        w_op1  = A;
        w_op2  = B;
        w_cin0 = 1'b0;
      end
      default: begin
        w_op1  = A;
        w_op2  = ~B;
        w_cin0 = 1'b1;
      end
    endcase
  end

  assign w_cin  = w_first ? w_cin0 : r_carry;
  assign w_sum  = w_op1 ^ w_op2 ^ w_cin;
  assign w_cout = (w_op1 & w_op2) | (w_op1 & w_cin) | (w_op2 & w_cin);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_mode    <= 2'b00;
      r_y       <= 1'b0;
      r_y_valid <= 1'b0;
      r_y_last  <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (En) begin
      r_y       <= w_sum;
      r_y_valid <= 1'b1;
      r_carry   <= w_cout;
      if (w_first) begin
        r_mode <= Mode;
      end
      // Overflow is the carry into the sign bit differing from the carry out of it.
      if (r_cnt == LAST_BIT) begin
        r_y_last <= 1'b1;
        r_ovf    <= w_cin ^ w_cout;
        r_cnt    <= '0;
      end else begin
        r_y_last <= 1'b0;
        r_ovf    <= 1'b0;
        r_cnt    <= r_cnt + 1'b1;
      end
    end else begin
      r_y_valid <= 1'b0;
      r_y_last  <= 1'b0;
      r_ovf     <= 1'b0;
    end
  end

  assign Y       = r_y;
  assign Y_Valid = r_y_valid;
  assign Y_Last  = r_y_last;
  assign Ovf     = r_ovf;
  assign Busy    = (r_cnt != '0);

endmodule

// File: tb/tb_serial_arith_unit.sv
// Directed bench for serial_arith_unit: a W=4 and a W=6 instance checked against
// hand-computed words covering negate, pass, add, subtract, stalls and reset.
module tb_serial_arith_unit;

  logic       clk;
  logic       rst;

  logic       en4, a4, b4;
  logic [1:0] mode4;
  logic       y4, v4, l4, o4, busy4;

  logic       en6, a6, b6;
  logic [1:0] mode6;
  logic       y6, v6, l6, o6, busy6;

  int n_cmp;
  int n_err;

  serial_arith_unit #(.W(4)) u_dut4 (
    .CLK(clk), .Reset(rst), .En(en4), .Mode(mode4), .A(a4), .B(b4),
    .Y(y4), .Y_Valid(v4), .Y_Last(l4), .Ovf(o4), .Busy(busy4)
  );

  serial_arith_unit #(.W(6)) u_dut6 (
    .CLK(clk), .Reset(rst), .En(en6), .Mode(mode6), .A(a6), .B(b6),
    .Y(y6), .Y_Valid(v6), .Y_Last(l6), .Ovf(o6), .Busy(busy6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One edge on the W=4 unit; outputs are sampled 1 time unit after the edge.
  task automatic drive4(input logic [1:0] mode, input logic a, input logic en);
    mode4 = mode; a4 = a; b4 = 1'b0; en4 = en;
    @(posedge clk);
    #1;
  endtask

  task automatic drive6(input logic [1:0] mode, input logic a, input logic b, input logic en);
    mode6 = mode; a6 = a; b6 = b; en6 = en;
    @(posedge clk);
    #1;
  endtask

  task automatic word4(input logic [1:0] mode, input logic [3:0] a,
                       output logic [3:0] y, output logic [3:0] vld,
                       output logic [3:0] last, output logic [3:0] ovf);
    for (int i = 0; i < 4; i++) begin
      drive4(mode, a[i], 1'b1);
      y[i] = y4; vld[i] = v4; last[i] = l4; ovf[i] = o4;
    end
    en4 = 1'b0;
  endtask

  task automatic word6(input logic [1:0] mode, input logic [5:0] a, input logic [5:0] b,
                       output logic [5:0] y, output logic [5:0] vld,
                       output logic [5:0] last, output logic [5:0] ovf);
    for (int i = 0; i < 6; i++) begin
      drive6(mode, a[i], b[i], 1'b1);
      y[i] = y6; vld[i] = v6; last[i] = l6; ovf[i] = o6;
    end
    en6 = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    rst = 1'b1;
    en4 = 1'b0; en6 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    obs = {y4, v4, l4, o4, busy4, y6, v6, l6, o6, busy6};
    n_cmp++;
    if (obs !== 10'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected %b", obs, 10'b0);
    end
    rst = 1'b0;
    $display("reset: outputs=%b", obs);
  endtask

  task automatic test_negate();
    logic [3:0] y, vld, last, ovf;
    word4(2'b01, 4'b1100, y, vld, last, ovf);
    $display("negate4 A=1100: Y=%b valid=%b last=%b ovf=%b", y, vld, last, ovf);
    n_cmp++;
    if (y !== 4'b0100) begin n_err++; $display("FAIL neg_y: got %b expected 0100", y); end
    n_cmp++;
    if (vld !== 4'b1111) begin n_err++; $display("FAIL neg_valid: got %b expected 1111", vld); end
    n_cmp++;
    if (last !== 4'b1000) begin n_err++; $display("FAIL neg_last: got %b expected 1000", last); end
    n_cmp++;
    if (ovf !== 4'b0000) begin n_err++; $display("FAIL neg_ovf: got %b expected 0000", ovf); end
    n_cmp++;
    if (busy4 !== 1'b0) begin n_err++; $display("FAIL neg_busy_end: got %b expected 0", busy4); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] y, vld, last, ovf;
    logic [3:0] y2, vld2, last2, ovf2;
    word4(2'b01, 4'b1000, y, vld, last, ovf);
    word4(2'b00, 4'b0110, y2, vld2, last2, ovf2);
    $display("negate4 A=1000: Y=%b ovf=%b; pass4 A=0110: Y=%b valid=%b ovf=%b",
             y, ovf, y2, vld2, ovf2);
    n_cmp++;
    if (y !== 4'b1000) begin n_err++; $display("FAIL negmin_y: got %b expected 1000", y); end
    n_cmp++;
    if (ovf !== 4'b1000) begin n_err++; $display("FAIL negmin_ovf: got %b expected 1000", ovf); end
    n_cmp++;
    if (y2 !== 4'b0110) begin n_err++; $display("FAIL pass_y: got %b expected 0110", y2); end
    n_cmp++;
    if (vld2 !== 4'b1111) begin n_err++; $display("FAIL pass_valid: got %b expected 1111", vld2); end
    n_cmp++;
    if (last2 !== 4'b1000) begin n_err++; $display("FAIL pass_last: got %b expected 1000", last2); end
    n_cmp++;
    if (ovf2 !== 4'b0000) begin n_err++; $display("FAIL pass_ovf: got %b expected 0000", ovf2); end
  endtask

  task automatic test_add_sub();
    logic [5:0] y, vld, last, ovf;
    word6(2'b10, 6'b011010, 6'b000111, y, vld, last, ovf);
    $display("add6 26+7: Y=%b last=%b ovf=%b", y, last, ovf);
    n_cmp++;
    if (y !== 6'b100001) begin n_err++; $display("FAIL add_y: got %b expected 100001", y); end
    n_cmp++;
    if (ovf !== 6'b100000) begin n_err++; $display("FAIL add_ovf: got %b expected 100000", ovf); end
    n_cmp++;
    if (last !== 6'b100000) begin n_err++; $display("FAIL add_last: got %b expected 100000", last); end
    word6(2'b11, 6'b011010, 6'b000111, y, vld, last, ovf);
    $display("sub6 26-7: Y=%b last=%b ovf=%b", y, last, ovf);
    n_cmp++;
    if (y !== 6'b010011) begin n_err++; $display("FAIL sub_y: got %b expected 010011", y); end
    n_cmp++;
    if (ovf !== 6'b000000) begin n_err++; $display("FAIL sub_ovf: got %b expected 000000", ovf); end
  endtask

  task automatic test_stall();
    logic [5:0] a, b, y, vld, last, ovf;
    a = 6'b011010;
    b = 6'b000111;
    y = '0; vld = '0; last = '0; ovf = '0;
    for (int i = 0; i < 3; i++) begin
      drive6(2'b11, a[i], b[i], 1'b1);
      y[i] = y6; vld[i] = v6; last[i] = l6; ovf[i] = o6;
    end
    // Stall three cycles with Mode flipped to pass; the word must not notice.
    for (int s = 0; s < 3; s++) begin
      drive6(2'b00, 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if ({v6, l6, o6, busy6, y6} !== 5'b00010) begin
        n_err++;
        $display("FAIL stall_cycle%0d: valid/last/ovf/busy/y got %b expected 00010",
                 s, {v6, l6, o6, busy6, y6});
      end
    end
    for (int i = 3; i < 6; i++) begin
      drive6(2'b00, a[i], b[i], 1'b1);
      y[i] = y6; vld[i] = v6; last[i] = l6; ovf[i] = o6;
    end
    en6 = 1'b0;
    $display("stalled sub6 26-7: Y=%b valid=%b ovf=%b", y, vld, ovf);
    n_cmp++;
    if (y !== 6'b010011) begin n_err++; $display("FAIL stall_y: got %b expected 010011", y); end
    n_cmp++;
    if (vld !== 6'b111111) begin n_err++; $display("FAIL stall_valid: got %b expected 111111", vld); end
    n_cmp++;
    if ({last, ovf} !== {6'b100000, 6'b000000}) begin
      n_err++;
      $display("FAIL stall_last_ovf: got %b/%b expected 100000/000000", last, ovf);
    end
  endtask

  task automatic test_mid_reset();
    logic [5:0] a, b, y, vld, last, ovf;
    a = 6'b011010;
    b = 6'b000111;
    for (int i = 0; i < 4; i++) begin
      drive6(2'b10, a[i], b[i], 1'b1);
    end
    rst = 1'b1;
    drive6(2'b10, a[4], b[4], 1'b1);
    rst = 1'b0;
    n_cmp++;
    if ({y6, v6, l6, o6, busy6} !== 5'b00000) begin
      n_err++;
      $display("FAIL midreset_outputs: got %b expected 00000", {y6, v6, l6, o6, busy6});
    end
    en6 = 1'b0;
    word6(2'b10, 6'b000001, 6'b000001, y, vld, last, ovf);
    $display("add6 after reset 1+1: Y=%b last=%b ovf=%b", y, last, ovf);
    n_cmp++;
    if (y !== 6'b000010) begin n_err++; $display("FAIL postreset_y: got %b expected 000010", y); end
    n_cmp++;
    if ({last, ovf} !== {6'b100000, 6'b000000}) begin
      n_err++;
      $display("FAIL postreset_last_ovf: got %b/%b expected 100000/000000", last, ovf);
    end
  endtask

  task automatic test_reset_hold();
    logic [5:0] y, vld, last, ovf;
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive6(2'b10, 1'b1, 1'b1, 1'b1);
      n_cmp++;
      if ({v6, busy6} !== 2'b00) begin
        n_err++;
        $display("FAIL reset_hold_cycle%0d: valid/busy got %b expected 00", c, {v6, busy6});
      end
    end
    rst = 1'b0;
    en6 = 1'b0;
    word6(2'b10, 6'b000011, 6'b000001, y, vld, last, ovf);
    $display("add6 after held reset 3+1: Y=%b last=%b", y, last);
    n_cmp++;
    if (y !== 6'b000100) begin n_err++; $display("FAIL reset_hold_y: got %b expected 000100", y); end
    n_cmp++;
    if (last !== 6'b100000) begin n_err++; $display("FAIL reset_hold_last: got %b expected 100000", last); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    en4 = 1'b0; mode4 = 2'b00; a4 = 1'b0; b4 = 1'b0;
    en6 = 1'b0; mode6 = 2'b00; a6 = 1'b0; b6 = 1'b0;
    test_reset();
    test_negate();
    test_back_to_back();
    test_add_sub();
    test_stall();
    test_mid_reset();
    test_reset_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
